// File: rtl/count_display_driver.sv
// rtl/count_display_driver.sv - two-digit muxed 7-segment driver and health monitor for the bouncing 0..15 counter
// Optional build macro: COUNT_DISPLAY_REV_CNT_EN enables the direction-reversal counter on rev_count.
module count_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cont,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dir_up,
    output logic       dir_valid,
    output logic       step_err,
    output logic [7:0] rev_count
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [1:0] AN_POL  = {2{ACTIVE_LOW}};

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    logic [3:0]    cont_q, cont_prev_q, ones_q, ones_d;
    logic          tens_q, tens_d;
    logic [CW-1:0] refresh_q, refresh_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d, raw_seg;
    logic [1:0]    an_q, an_d, raw_an;
    logic          dir_up_q, dir_up_d, dir_valid_q, dir_valid_d, step_err_q, step_err_d;
    logic          moved_up, moved_down;

    always_comb begin
        tens_d = (cont_q >= 4'd10);
        ones_d = tens_d ? (cont_q - 4'd10) : cont_q;

        refresh_d = (refresh_q == REFRESH_LAST) ? '0 : refresh_q + 1'b1;
        sel_d     = (refresh_q == REFRESH_LAST) ? ~sel_q : sel_q;

        // Tens slot with a zero tens digit is blanked entirely (leading-zero suppression).
        raw_seg = 7'b0000000;
        raw_an  = 2'b00;
        if (!sel_q) begin
            raw_seg = seg_decode(ones_q);
            raw_an  = 2'b01;
        end else if (tens_q) begin
            raw_seg = seg_decode({3'b000, tens_q});
            raw_an  = 2'b10;
        end
        seg_d = raw_seg ^ SEG_POL;
        an_d  = raw_an ^ AN_POL;

        moved_up    = (cont_q > cont_prev_q);
        moved_down  = (cont_q < cont_prev_q);
        dir_up_d    = moved_up ? 1'b1 : (moved_down ? 1'b0 : dir_up_q);
        dir_valid_d = dir_valid_q | moved_up | moved_down;
        // Magnitude compare rather than modular difference so 15<->0 wraps count as errors.
        step_err_d  = step_err_q
                    | (moved_up   && ((cont_q - cont_prev_q) != 4'd1))
                    | (moved_down && ((cont_prev_q - cont_q) != 4'd1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q      <= 4'd0;
            cont_prev_q <= 4'd0;
            tens_q      <= 1'b0;
            ones_q      <= 4'd0;
            refresh_q   <= '0;
            sel_q       <= 1'b0;
            seg_q       <= SEG_POL;
            an_q        <= 2'b01 ^ AN_POL;
            dir_up_q    <= 1'b1;
            dir_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            cont_q      <= cont;
            cont_prev_q <= cont_q;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dir_up_q    <= dir_up_d;
            dir_valid_q <= dir_valid_d;
            step_err_q  <= step_err_d;
        end
    end

`ifdef COUNT_DISPLAY_REV_CNT_EN
    logic [7:0] rev_q, rev_d;

    always_comb begin
        rev_d = rev_q;
        if (dir_valid_q && (dir_up_d != dir_up_q) && (rev_q != 8'hFF))
            rev_d = rev_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) rev_q <= 8'd0;
        else       rev_q <= rev_d;
    end

    assign rev_count = rev_q;
`else
    assign rev_count = 8'd0;
`endif

    assign seg       = seg_q;
    assign an        = an_q;
    assign dir_up    = dir_up_q;
    assign dir_valid = dir_valid_q;
    assign step_err  = step_err_q;
endmodule

// File: tb/tb_count_display_driver.sv
// tb/tb_count_display_driver.sv - randomized self-checking bench for count_display_driver
module tb_count_display_driver;
    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cont  = 4'd0;

    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;
    logic       dir_up_a, dir_valid_a, step_err_a, dir_up_b, dir_valid_b, step_err_b;
    logic [7:0] rev_a, rev_b;

    count_display_driver #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_hi (
        .clock(clock), .reset(reset), .cont(cont), .seg(seg_a), .an(an_a),
        .dir_up(dir_up_a), .dir_valid(dir_valid_a), .step_err(step_err_a), .rev_count(rev_a)
    );

    count_display_driver #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_lo (
        .clock(clock), .reset(reset), .cont(cont), .seg(seg_b), .an(an_b),
        .dir_up(dir_up_b), .dir_valid(dir_valid_b), .step_err(step_err_b), .rev_count(rev_b)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference: hist[k] is the cont value present at the k-th edge since reset (hist[0] = reset state).
    int         hist[$];
    int         edge_n;
    bit         m_dir, m_val, m_err;
    int         m_rev;
    logic [6:0] exp_seg, inv_seg;
    logic [1:0] exp_an, inv_an;

    function automatic int h(input int k);
        if (k < 0 || k >= hist.size()) return 0;
        return hist[k];
    endfunction

    task automatic tick(input logic [3:0] v, input bit rst);
        int cur, prev, sel, dv, diff;
        bit new_dir;
        cont  = v;
        reset = rst;
        @(posedge clock);
        if (rst) begin
            hist.delete();
            hist.push_back(0);
            edge_n  = 0;
            m_dir   = 1'b1;
            m_val   = 1'b0;
            m_err   = 1'b0;
            m_rev   = 0;
            exp_seg = 7'h00;
            exp_an  = 2'b01;
        end else begin
            edge_n++;
            hist.push_back(int'(v));
            cur  = h(edge_n - 1);
            prev = h(edge_n - 2);
            if (cur != prev) begin
                new_dir = (cur > prev);
                if (m_val && new_dir != m_dir && m_rev < 255) m_rev++;
                m_dir = new_dir;
                m_val = 1'b1;
                diff  = (cur > prev) ? cur - prev : prev - cur;
                if (diff != 1) m_err = 1'b1;
            end
            sel = ((edge_n - 1) / DIV) % 2;
            dv  = h(edge_n - 2);
            if (sel == 0) begin
                exp_seg = digit_pat[dv % 10];
                exp_an  = 2'b01;
            end else if (dv < 10) begin
                exp_seg = 7'h00;
                exp_an  = 2'b00;
            end else begin
                exp_seg = digit_pat[1];
                exp_an  = 2'b10;
            end
        end
        #1;
        inv_seg = ~exp_seg;
        inv_an  = ~exp_an;
        check_eq("seg_hi", {25'd0, seg_a}, {25'd0, exp_seg});
        check_eq("an_hi", {30'd0, an_a}, {30'd0, exp_an});
        check_eq("seg_lo", {25'd0, seg_b}, {25'd0, inv_seg});
        check_eq("an_lo", {30'd0, an_b}, {30'd0, inv_an});
        check_eq("dir_up", {31'd0, dir_up_a}, {31'd0, m_dir});
        check_eq("dir_valid", {31'd0, dir_valid_a}, {31'd0, m_val});
        check_eq("step_err", {31'd0, step_err_a}, {31'd0, m_err});
        check_eq("step_err_lo", {31'd0, step_err_b}, {31'd0, m_err});
`ifdef COUNT_DISPLAY_REV_CNT_EN
        check_eq("rev_count", {24'd0, rev_a}, m_rev);
`else
        check_eq("rev_count", {24'd0, rev_a}, 32'd0);
`endif
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    task automatic legal_walk(input int n);
        int c;
        c = int'(cont);
        for (int i = 0; i < n; i++) begin
            c = c + int'($urandom_range(0, 2)) - 1;
            if (c < 0)  c = 0;
            if (c > 15) c = 15;
            tick(4'(c), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(4'($urandom), 1'b1);

        // Two bounce periods with random dwell per value
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 15; i++) hold(4'(i), 1 + int'($urandom_range(0, 2)));
            for (int i = 14; i >= 0; i--) hold(4'(i), 1 + int'($urandom_range(0, 2)));
        end
        hold(4'd0, 3);
        check_eq("bounce_no_err", {31'd0, step_err_a}, 32'd0);
        legal_walk(80);

        tick(4'd0, 1'b1);
        hold(4'd7, 12);
        hold(4'd13, 12);

        tick(4'd0, 1'b1);
        hold(4'd4, 2);
        hold(4'd5, 2);
        hold(4'd9, 4);
        check_eq("jump_err", {31'd0, step_err_a}, 32'd1);
        legal_walk(20);

        tick(4'd0, 1'b1);
        tick(4'd0, 1'b1);
        hold(4'd0, 6);
        tick(4'd0, 1'b1);
        hold(4'd0, 12);

        for (int i = 0; i < 60; i++) tick(4'($urandom), 1'b0);
        tick(4'd0, 1'b1);
        legal_walk(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit bouncing up/down counter value (0..15..0).
- Samples the count, converts it to two decimal digits (00..15) and drives a time-multiplexed two-digit 7-segment display.
- Tracks count direction and flags illegal steps, so a board-level observer can confirm counter health.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled before the mux switches; legal range 2..2^20.
- ACTIVE_LOW, 1, when 1 both seg and an are driven inverted (common-anode board); when 0 they are active-high.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cont  input  4  count value from the upstream counter; treated as unsigned, sampled every cycle.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  output  2  digit enables; an[0] = ones digit, an[1] = tens digit; polarity per ACTIVE_LOW.
- dir_up  output  1  1 = count last moved up, 0 = last moved down.
- dir_valid  output  1  high once at least one change of the sampled value has been seen.
- step_err  output  1  sticky flag: consecutive differing samples did not differ by exactly 1.
- rev_count  output  8  direction-reversal count; see Optional Feature.

Behaviour:
- Reset, synchronous, applies regardless of any other input:
  - cont_q = 0, cont_prev = 0, tens = 0, ones = 0.
  - Refresh counter = 0, digit select = ones.
  - dir_up = 1, dir_valid = 0, step_err = 0, rev_count = 0.
  - seg/an outputs register to all segments off and ones digit enabled, in the configured polarity.
- Stage 1: cont_q <= cont every cycle; cont_prev <= cont_q.
- Stage 2 (BCD):
  - If cont_q >= 10: tens = 1, ones = cont_q - 10.
  - Otherwise: tens = 0, ones = cont_q.
  - Registered; 4-bit arithmetic, no overflow possible.
- Stage 3 (registered output): the selected digit is decoded with the standard 0-9 patterns; active-high internal values are 0=0111111, 1=0000110, 5=1101101, 9=1101111.
- Latency: a cont change reaches seg 3 cycles later, provided that digit is selected.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1.
  - At the terminal value it wraps to 0 and digit select toggles on the same edge.
  - an changes with the seg update from stage 3, so there is no glitch window between an and seg.
- Leading-zero blanking: when the tens digit is selected and tens = 0, an[1] is deasserted and all segments are off. The ones digit is never blanked.
- Direction, evaluated on cont_q vs cont_prev each cycle:
  - greater: dir_up <= 1 and dir_valid <= 1.
  - less: dir_up <= 0 and dir_valid <= 1.
  - equal: all direction state holds.
- Step check:
  - If cont_q != cont_prev and |cont_q - cont_prev| != 1, step_err <= 1.
  - Wrap steps 15->0 and 0->15 are errors.
  - step_err is cleared only by reset.
- The first sample after reset is compared against cont_prev = 0, so a nonzero first value sets step_err unless it is 1. The upstream counter shares this reset, so this does not occur in normal use.
- Held input: outputs static except for the digit mux. dir_up holds its last value indefinitely.
- Upstream bounce points (14->15->14, 1->0->1): dir_up flips on the cycle after cont_q shows the reversal; no error is raised.

Optional Feature:
- Macro: COUNT_DISPLAY_REV_CNT_EN.
- Defined:
  - rev_count increments by 1 on every cycle where dir_up changes value while dir_valid was already 1.
  - It saturates at 255 and resets to 0.
- Undefined: rev_count is tied to 8'd0 and no reversal logic is synthesized. Port list is identical in both builds.

Test Plan:
- REFRESH_DIV=4, ACTIVE_LOW=0, hold reset 3 cycles -> seg=0000000, an=01, dir_up=1, dir_valid=0, step_err=0, rev_count=0.
- cont=7 steady -> 3 cycles later, on each ones slot: seg=0000111, an=01. On each tens slot: an=00 (blanked). Slots alternate every 4 cycles.
- cont=13 steady -> ones slot: seg=1001111 (3), an=01; tens slot: seg=0000110 (1), an=10.
- Drive a full bounce 0..15..0 at one step per cycle:
  - dir_up=1 through the rise, 0 after the 15->14 sample, back to 1 after 0->1.
  - step_err stays 0.
  - With macro: rev_count=2 after one full period.
- Inject 5 then 9 -> step_err=1 two cycles after 9 is applied; dir_up=1; step_err stays 1 after cont returns to legal steps, until reset.
- ACTIVE_LOW=1, cont=0, plus reset asserted mid-refresh slot:
  - Before reset: ones slot shows seg=1000000, an=10 (inverted).
  - Reset returns the refresh counter and digit select to their reset values on the next edge.
  - Without macro: rev_count=0 throughout all tests.
